// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per cycle, LSB first, and
// reports the difference with unsigned borrow and signed overflow flags.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic [1:0]       state_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic ai, bi, d_bit, br_next, last_bit;

    assign ai       = a_q[0];
    assign bi       = b_q[0];
    assign d_bit    = ai ^ bi ^ br_q;
    assign br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                // On the last bit ai/bi are the operand MSBs and d_bit is the result MSB.
                if (last_bit) begin
                    state_d  = S_DONE;
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = br_next;
                    ovf_d    = (ai ^ bi) & (d_bit ^ ai);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 (directed) and WIDTH=4 (full sweep).
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, borrow8, ovf8;
    logic [7:0] diff8;
    logic [1:0] st8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, borrow4, ovf4;
    logic [3:0] diff4;
    logic [1:0] st4;

    logic [9:0] exp_q[$];
    logic [5:0] exp4_q[$];

    int checks = 0;
    int errors = 0;
    logic [7:0] last_diff8 = '0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8),
        .overflow(ovf8), .state_o(st8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4),
        .overflow(ovf4), .state_o(st4)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] d;
        d = x - y;
        return {d, (x < y), ((x[3] != y[3]) && (d[3] != x[3]))};
    endfunction

    // Monitor: pops the expected queue whenever a done pulse is presented.
    initial begin
        logic [9:0] e8;
        logic [5:0] e4;
        forever begin
            @(negedge clk);
            if (done8) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done8: got diff=%0h with empty queue", diff8);
                end else begin
                    e8 = exp_q.pop_front();
                    if ({diff8, borrow8, ovf8} !== e8) begin
                        errors++;
                        $display("FAIL result8: got diff=%0h br=%0b ov=%0b, want diff=%0h br=%0b ov=%0b",
                                 diff8, borrow8, ovf8, e8[9:2], e8[1], e8[0]);
                    end
                end
            end
            if (done4) begin
                checks++;
                if (exp4_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done4: got diff=%0h with empty queue", diff4);
                end else begin
                    e4 = exp4_q.pop_front();
                    if ({diff4, borrow4, ovf4} !== e4) begin
                        errors++;
                        $display("FAIL result4: got diff=%0h br=%0b ov=%0b, want diff=%0h br=%0b ov=%0b",
                                 diff4, borrow4, ovf4, e4[5:2], e4[1], e4[0]);
                    end
                end
            end
        end
    end

    // One WIDTH=8 operation; operands are scrambled right after acceptance.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [9:0] exp);
        int lat;
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        check("busy_after_start", 32'(busy8), 32'd1);
        lat = 0;
        while (!done8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 4) check("diff_hold_mid_run", 32'(diff8), 32'(last_diff8));
        end
        check("latency8", lat, 8);
        last_diff8 = exp[9:2];
        @(posedge clk); #1;
        check("busy_after_done", 32'(busy8), 32'd0);
        check("done_one_cycle", 32'(done8), 32'd0);
    endtask

    task automatic run4(input logic [3:0] av, input logic [3:0] bv);
        int lat;
        @(negedge clk);
        a4 = av; b4 = bv; start4 = 1'b1;
        exp4_q.push_back(model4(av, bv));
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = ~av; b4 = ~bv;
        lat = 0;
        while (!done4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat != 4) check("latency4", lat, 4);
        @(posedge clk); #1;
    endtask

    initial begin
        int ndone, last_k, gap_err;

        // Reset state
        #2;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_flags", 32'({borrow8, ovf8}), 32'd0);
        check("rst_state", 32'(st8), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        run8(8'h05, 8'h03, {8'h02, 1'b0, 1'b0});
        run8(8'h03, 8'h05, {8'hFE, 1'b1, 1'b0});
        run8(8'h80, 8'h01, {8'h7F, 1'b0, 1'b1});
        run8(8'h7F, 8'hFF, {8'h80, 1'b1, 1'b1});
        run8(8'hA5, 8'hA5, {8'h00, 1'b0, 1'b0});

        // Start held high for 30 cycles: accepted every 10 cycles
        repeat (3) exp_q.push_back({8'h0F, 1'b0, 1'b0});
        ndone = 0; last_k = -1; gap_err = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            start8 = 1'b1;
            if (k % 10 == 0) begin a8 = 8'h10; b8 = 8'h01; end
            else begin a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255)); end
            @(posedge clk); #1;
            if (done8) begin
                if (last_k >= 0 && (k - last_k) != 10) gap_err++;
                last_k = k;
                ndone++;
            end
        end
        @(negedge clk);
        start8 = 1'b0;
        check("held_start_done_count", ndone, 3);
        check("held_start_period", gap_err, 0);
        last_diff8 = 8'h0F;
        repeat (3) @(posedge clk);

        // Reset 4 cycles into RUN abandons the operation
        @(negedge clk);
        a8 = 8'h20; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrun_rst_busy", 32'(busy8), 32'd0);
        check("midrun_rst_diff", 32'(diff8), 32'd0);
        check("midrun_rst_flags", 32'({borrow8, ovf8, done8}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_diff8 = 8'h00;
        repeat (12) @(posedge clk);
        run8(8'h00, 8'h01, {8'hFF, 1'b1, 1'b0});

        // WIDTH=4 exhaustive sweep
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run4(4'(i), 4'(j));

        repeat (4) @(posedge clk);
        check("queue8_drained", exp_q.size(), 0);
        check("queue4_drained", exp4_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
